// File: rtl/pwm_tick_gen_if.sv
// Configuration port for pwm_tick_gen: requested period/duty, load strobe and apply acknowledge.
interface pwm_tick_gen_if #(
   parameter int CNT_W = 16
);
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] duty;
   logic             load;
   logic             load_ack;

   modport master (output period, output duty, output load, input load_ack);
   modport slave  (input period, input duty, input load, output load_ack);
endinterface

// File: rtl/pwm_tick_gen.sv
// Tick-based PWM generator with shadow-buffered period/duty applied only at period boundaries.
//  state | meaning
//  IDLE  | counter and output held at 0, pending config applied immediately
//  RUN   | counting ticks, pending config applied at wrap, disable, or tick when period is 0
module pwm_tick_gen #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          en,
   pwm_tick_gen_if.slave cfg,
   output logic          pwm_out,
   output logic          period_done
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] period_s, period_s_nxt;
   logic [CNT_W-1:0] duty_s, duty_s_nxt;
   logic [CNT_W-1:0] pend_period, pend_period_nxt;
   logic [CNT_W-1:0] pend_duty, pend_duty_nxt;
   logic             pend_flag, pend_flag_nxt;
   logic             load_ack_q, load_ack_nxt;
   logic             pwm_nxt, period_done_nxt;
   logic             running, wrap, zero_tick, apply, have_pend;
   logic [CNT_W-1:0] period_in, duty_in;

   always_ff @(posedge clk) begin : state_reg
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (en)  state_nxt = RUN;
         RUN:     if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin : datapath_next
      running   = (state == RUN) && en;
      wrap      = running && tick && (period_s != '0) && (cnt == period_s - ONE);
      zero_tick = running && tick && (period_s == '0);

      // A load seen this cycle wins over an older pending value.
      have_pend = cfg.load || pend_flag;
      period_in = cfg.load ? cfg.period : pend_period;
      duty_in   = cfg.load ? cfg.duty   : pend_duty;
      apply     = have_pend && ((state == IDLE) || !en || wrap || zero_tick);

      pend_period_nxt = cfg.load ? cfg.period : pend_period;
      pend_duty_nxt   = cfg.load ? cfg.duty   : pend_duty;
      pend_flag_nxt   = have_pend && !apply;

      period_s_nxt = apply ? period_in : period_s;
      duty_s_nxt   = apply ? duty_in   : duty_s;

      cnt_nxt = '0;
      if (running) begin
         if (tick && (period_s != '0)) cnt_nxt = wrap ? '0 : cnt + ONE;
         else                          cnt_nxt = cnt;
      end

      // Output is built from next-state values so it stays aligned with cnt.
      pwm_nxt         = (state_nxt == RUN) && (period_s_nxt != '0) && (cnt_nxt < duty_s_nxt);
      period_done_nxt = wrap;
      load_ack_nxt    = apply;
   end

   always_ff @(posedge clk) begin : datapath_reg
      if (rst) begin
         cnt         <= '0;
         period_s    <= '0;
         duty_s      <= '0;
         pend_period <= '0;
         pend_duty   <= '0;
         pend_flag   <= 1'b0;
         pwm_out     <= 1'b0;
         load_ack_q  <= 1'b0;
         period_done <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         period_s    <= period_s_nxt;
         duty_s      <= duty_s_nxt;
         pend_period <= pend_period_nxt;
         pend_duty   <= pend_duty_nxt;
         pend_flag   <= pend_flag_nxt;
         pwm_out     <= pwm_nxt;
         load_ack_q  <= load_ack_nxt;
         period_done <= period_done_nxt;
      end
   end

   assign cfg.load_ack = load_ack_q;
endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed self-checking bench for pwm_tick_gen with hand-derived waveforms.
module tb_pwm_tick_gen;
   logic clk = 1'b0;
   logic rst, tick, en, pwm_out, period_done;
   int   n_chk = 0;
   int   n_err = 0;
   int   npd, acks;

   pwm_tick_gen_if #(.CNT_W(16)) cfg ();

   pwm_tick_gen #(.CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (en),
      .cfg         (cfg.slave),
      .pwm_out     (pwm_out),
      .period_done (period_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] p, input logic [15:0] d);
      cfg.period = p;
      cfg.duty   = d;
      cfg.load   = 1'b1;
      cyc();
      cfg.load   = 1'b0;
   endtask

   task automatic idle_load(input logic [15:0] p, input logic [15:0] d);
      en   = 1'b0;
      tick = 1'b0;
      cyc();
      do_load(p, d);
      chk("idle_load_ack", cfg.load_ack, 1);
   endtask

   logic exp_pwm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic exp_pd  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic exp_ack [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      rst = 1'b1; en = 1'b0; tick = 1'b0;
      cfg.load = 1'b0; cfg.period = '0; cfg.duty = '0;

      // reset dominates en/tick
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick = ~tick;
         cyc();
         chk("rst_pwm", pwm_out, 0);
         chk("rst_ack", cfg.load_ack, 0);
         chk("rst_pd", period_done, 0);
      end
      rst = 1'b0; en = 1'b0; tick = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("idle_pwm", pwm_out, 0);
         chk("idle_ack", cfg.load_ack, 0);
         chk("idle_pd", period_done, 0);
      end

      // basic 4/1
      do_load(4, 1);
      chk("basic_ack", cfg.load_ack, 1);
      chk("basic_pwm_idle", pwm_out, 0);
      en = 1'b1; tick = 1'b1;
      cyc();
      chk("basic_pwm_start", pwm_out, 1);
      chk("basic_ack_clear", cfg.load_ack, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("basic_pwm", pwm_out, (k % 4) == 0);
         chk("basic_pd", period_done, (k % 4) == 0);
      end

      // shadowed update 8/2 -> 8/6 loaded at cnt=3
      idle_load(8, 2);
      en = 1'b1; tick = 1'b1;
      cyc();
      chk("shadow_pwm0", pwm_out, 1);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         chk("shadow_pwm_a", pwm_out, c < 2);
      end
      do_load(8, 6);
      chk("shadow_ack_early", cfg.load_ack, 0);
      chk("shadow_pwm4", pwm_out, 0);
      for (int c = 5; c <= 7; c++) begin
         cyc();
         chk("shadow_pwm_b", pwm_out, 0);
         chk("shadow_ack_b", cfg.load_ack, 0);
      end
      cyc();
      chk("shadow_pd_wrap", period_done, 1);
      chk("shadow_ack_wrap", cfg.load_ack, 1);
      chk("shadow_pwm_wrap", pwm_out, 1);
      for (int c = 1; c <= 7; c++) begin
         cyc();
         chk("shadow_pwm_new", pwm_out, c < 6);
         chk("shadow_ack_new", cfg.load_ack, 0);
      end
      cyc();
      chk("shadow_pd2", period_done, 1);
      chk("shadow_ack2", cfg.load_ack, 0);

      // duty 0
      idle_load(8, 0);
      en = 1'b1; tick = 1'b1;
      cyc();
      chk("d0_pwm0", pwm_out, 0);
      npd = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk("d0_pwm", pwm_out, 0);
         chk("d0_pd", period_done, (k % 8) == 0);
         if (period_done) npd++;
      end
      chk("d0_pd_count", npd, 2);

      // duty == period
      idle_load(8, 8);
      en = 1'b1; tick = 1'b1;
      cyc();
      chk("dfull_pwm0", pwm_out, 1);
      for (int k = 1; k <= 10; k++) begin
         cyc();
         chk("dfull_pwm", pwm_out, 1);
         chk("dfull_pd", period_done, k == 8);
      end

      // period 0, then a load applied on the next tick
      idle_load(0, 3);
      en = 1'b1; tick = 1'b1;
      cyc();
      chk("p0_pwm0", pwm_out, 0);
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("p0_pwm", pwm_out, 0);
         chk("p0_pd", period_done, 0);
      end
      tick = 1'b0;
      do_load(4, 2);
      chk("p0_ack_notick", cfg.load_ack, 0);
      tick = 1'b1;
      cyc();
      chk("p0_ack_tick", cfg.load_ack, 1);
      chk("p0_pwm_tick", pwm_out, 1);
      chk("p0_pd_tick", period_done, 0);
      cyc();
      chk("p0_pwm_c1", pwm_out, 1);
      cyc();
      chk("p0_pwm_c2", pwm_out, 0);

      // disable at cnt=5 with pending 10/3
      idle_load(8, 4);
      en = 1'b1; tick = 1'b1;
      cyc();
      for (int c = 1; c <= 4; c++) begin
         cyc();
         chk("dis_pwm", pwm_out, c < 4);
      end
      do_load(10, 3);
      chk("dis_ack_pend", cfg.load_ack, 0);
      chk("dis_pwm5", pwm_out, 0);
      en = 1'b0;
      cyc();
      chk("dis_pwm_off", pwm_out, 0);
      chk("dis_ack", cfg.load_ack, 1);
      chk("dis_pd", period_done, 0);
      cyc();
      chk("dis_ack_clear", cfg.load_ack, 0);
      chk("dis_pwm_idle", pwm_out, 0);
      en = 1'b1;
      cyc();
      chk("reen_pwm0", pwm_out, 1);
      for (int k = 1; k <= 10; k++) begin
         cyc();
         chk("reen_pwm", pwm_out, (k % 10) < 3);
         chk("reen_pd", period_done, k == 10);
      end

      // sparse ticks, load coinciding with a wrap tick
      idle_load(3, 1);
      en = 1'b1; tick = 1'b0;
      cyc();
      chk("sparse_pwm0", pwm_out, 1);
      acks = 0;
      for (int j = 0; j < 5; j++) begin
         tick = 1'b1;
         if (j == 2) begin
            cfg.period = 3; cfg.duty = 2; cfg.load = 1'b1;
         end
         cyc();
         tick = 1'b0; cfg.load = 1'b0;
         chk("sparse_pwm", pwm_out, exp_pwm[j]);
         chk("sparse_pd", period_done, exp_pd[j]);
         chk("sparse_ack", cfg.load_ack, exp_ack[j]);
         if (cfg.load_ack) acks++;
         for (int q = 0; q < 4; q++) begin
            cyc();
            chk("sparse_hold_pwm", pwm_out, exp_pwm[j]);
            chk("sparse_hold_pd", period_done, 0);
            if (cfg.load_ack) acks++;
         end
      end
      chk("sparse_ack_count", acks, 1);

      // reset mid-period clears pending and shadow state
      do_load(5, 5);
      chk("mid_ack_pend", cfg.load_ack, 0);
      rst = 1'b1;
      cyc();
      chk("mid_rst_pwm", pwm_out, 0);
      chk("mid_rst_ack", cfg.load_ack, 0);
      chk("mid_rst_pd", period_done, 0);
      rst = 1'b0;
      cyc();
      chk("post_rst_ack", cfg.load_ack, 0);
      chk("post_rst_pwm", pwm_out, 0);
      tick = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("post_rst_pwm_t", pwm_out, 0);
         chk("post_rst_pd_t", period_done, 0);
         chk("post_rst_ack_t", cfg.load_ack, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pwm_tick_gen.md
Name: pwm_tick_gen

Overview:
- Downstream consumer of the free-running tick counter's `trigger` strobe.
- Uses each trigger pulse as its time base to generate a PWM waveform.
- Period and duty are programmable and shadow-buffered, so updates take effect only at a period boundary. This keeps the output glitch-free.
- Feeds motor/LED driver pins and reports period completion to control logic.

Parameters:
- CNT_W, 16, width of period, duty and internal period counter

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle time-base strobe from upstream counter trigger
- en  input  1  level; 1 = run PWM, 0 = idle
- period  input  CNT_W  requested period, in ticks
- duty  input  CNT_W  requested high time, in ticks
- load  input  1  one-cycle request to capture period/duty
- load_ack  output  1  one-cycle pulse when captured values become active
- pwm_out  output  1  registered PWM output
- period_done  output  1  one-cycle pulse at each period wrap

Behaviour:
- Reset: when rst=1 at a clk edge, clear the following to 0:
  - state (=IDLE), cnt, period_s, duty_s
  - pend_period, pend_duty, pend_flag
  - pwm_out, load_ack, period_done
- Reset dominates all other inputs.
- States:
  - IDLE: cnt=0, pwm_out=0.
    - en=1 → RUN on next edge, cnt starts at 0.
    - Pending values are applied in the same edge as the load is seen, or immediately if already pending.
  - RUN → IDLE on any edge where en=0.
    - Counter and output clear at that edge; no period_done.
    - Any pending load is applied at that edge, with load_ack.
- Load capture:
  - load=1 latches period/duty into pend_* and sets pend_flag.
  - A second load before apply overwrites pend_*; only one load_ack is issued, for the last value.
- Counting (RUN): cnt advances only on edges where tick=1.
  - If cnt == period_s-1: cnt←0, period_done←1 for one cycle.
  - If pend_flag at that wrap: period_s/duty_s←pending, pend_flag←0, load_ack←1 for one cycle.
  - load and wrap in the same cycle: the same-cycle load values are applied at that wrap.
- Output: pwm_out is registered from next-state values: pwm_out_next = (RUN_next) && (cnt_next < duty_s_next).
  - pwm_out is therefore aligned with cnt, with no combinational path to the pin.
- Boundaries:
  - period_s=0:
    - cnt holds 0, pwm_out=0, period_done never asserts.
    - Pending loads are applied on the next tick edge, with ack.
  - duty_s=0: pwm_out constantly 0; period_done still pulses.
  - duty_s >= period_s (period_s>0): pwm_out constantly 1.
  - tick with en=0: ignored.
  - en rising together with tick: first tick counted in the cycle after RUN is entered.
- Arithmetic: unsigned compares; cnt never exceeds period_s-1 (period_s>0), so no overflow.
- Latency:
  - tick edge → pwm_out change: visible the cycle after tick (registered).
  - Applied load → new duty visible in the same cycle as load_ack.

Test Plan:
1. Reset/idle: assert rst 3 cycles with en=1, tick toggling.
   → pwm_out=0, load_ack=0, period_done=0 throughout; after release with en=0, outputs stay 0.
2. Basic PWM: load period=4, duty=1 while IDLE (ack next cycle), then en=1, tick every cycle.
   → pwm_out pattern 1,0,0,0 repeating; period_done pulses every 4 ticks on the cnt 3→0 wrap.
3. Shadowed update: running period=8, duty=2; load period=8, duty=6 at mid-period (cnt=3).
   → current period keeps duty 2; load_ack and new duty 6 coincide with the next period_done.
4. Extremes:
   - duty=0 → pwm_out stuck 0 for 20 ticks, period_done still every 8 ticks.
   - duty=8, period=8 → pwm_out stuck 1.
   - period=0 → pwm_out 0, no period_done.
5. Disable mid-operation: en drops at cnt=5 with a pending load (period=10, duty=3).
   → next edge: pwm_out=0, cnt=0, load_ack=1, no period_done; re-enable → pattern uses period 10/duty 3.
6. Sparse tick / simultaneous events: tick every 5 clocks; load issued in the same cycle as a wrap tick.
   → counter advances only on ticks; new values applied at that wrap; exactly one load_ack.
   → A rst in the middle of a period clears all state on that edge.
